learning_neuron_fx: RTL
=======================

# learning_neuron_fx

Parametrised fixed-point successor to the real-valued learning neuron. It has a configurable input count, a configurable data format and a selectable activation. It computes a masked weighted sum serially with one multiply-accumulate per clock, then applies the activation and waits for an error term. With that error it performs an on-chip gradient update of its weights and bias, and produces a per-input back-propagated error for the upstream layer. Instances chain layer-to-layer: `back_err` of a downstream neuron feeds `err_in` of the upstream neuron.

## Interface
Parameters:
- N_INPUTS, 32, number of synaptic inputs (≥1)
- DATA_W, 16, signed two's-complement data/weight width
- FRAC_W, 8, fractional bits; 1.0 = 1<<FRAC_W
- LR_SHIFT, 3, learning rate = 2^-LR_SHIFT
- ACT_MODE, 0, 0 = step (1.0 if sum>0 else 0), 1 = ReLU saturated to max positive
- W_INIT, 1<<FRAC_W, reset value of every weight
- BIAS_INIT, 0, reset value of bias

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input vector offered
- in_ready  out  1  high only in IDLE
- in_vec  in  N_INPUTS*DATA_W  input i at [i*DATA_W +: DATA_W]
- en_mask  in  N_INPUTS  1 = input enabled; captured with in_vec
- learn_en  in  1  captured with in_vec; 0 = inference only
- out_valid  out  1  activation valid
- out_act  out  DATA_W  activation result
- err_valid  in  1  error term offered
- err_in  in  DATA_W  delta (expected − actual, pre-scaled by caller)
- back_valid  out  1  one-cycle pulse, back_err valid, update finished
- back_err  out  N_INPUTS*DATA_W  err × old weight per input; 0 for disabled inputs
- w_rd_idx  in  clog2(N_INPUTS+1)  debug read index; N_INPUTS selects bias
- w_rd_data  out  DATA_W  combinational read of the selected weight or bias

## Operation
- States: IDLE → MAC → ACT → (WAIT_ERR → UPDATE → DONE) → IDLE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, capture `in_vec`, `en_mask` and `learn_en`, clear the accumulator to bias<<FRAC_W, then go to MAC.
- MAC: for index i = 0..N_INPUTS−1, one per cycle: acc += en_mask[i] ? in_i*w_i : 0.
  - Accumulator width is 2*DATA_W+clog2(N_INPUTS+1), signed, never overflows.
- ACT: sum = acc >>> FRAC_W (arithmetic shift, floor), saturated to DATA_W.
  - Step mode: out_act = (sum>0) ? 1<<FRAC_W : 0.
  - ReLU mode: out_act = max(sum,0).
  - Register the result and set `out_valid`.
- learn_en=0: `out_valid` is high for exactly one cycle, then the block returns to IDLE. No weight changes. `err_valid` is ignored.
- learn_en=1: go to WAIT_ERR. Hold `out_valid` and `out_act` until `err_valid`=1. Latch `err_in` in that cycle, drop `out_valid` next cycle, go to UPDATE.
- UPDATE: for index i = 0..N_INPUTS−1, one per cycle, only if en_mask[i]:
  - back_err_i = sat((err*w_i_old) >>> FRAC_W)
  - w_i = sat(w_i + ((err*in_i) >>> (FRAC_W+LR_SHIFT)))
  - The bias updates on the first UPDATE cycle: bias = sat(bias + (err >>> LR_SHIFT)).
- DONE: `back_valid`=1 for one cycle, then IDLE.
- All saturations clamp to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Weights and bias persist across transactions. Only `rst` reloads them.

## Timing
- Reset values: `in_ready`=1 after reset; during the rst cycle itself it is 0. `out_valid`=0, `out_act`=0, `back_valid`=0, `back_err`=0, weights=W_INIT, bias=BIAS_INIT, state IDLE.
- Acceptance edge is T. `out_valid` is first high at edge T+N_INPUTS+2.
- `err_valid` is sampled at edge E, where E is the earliest edge at which `out_valid` is high. `back_valid` pulses at edge E+N_INPUTS+2. `in_ready` returns high one edge later.
- Inference-only throughput: one vector per N_INPUTS+3 cycles.
- `err_valid` outside WAIT_ERR is ignored. `in_valid` outside IDLE is ignored.
- `rst` asserted in any state aborts the transaction. The next edge shows the reset values, and a partial update is discarded because weights reload.
- `w_rd_data` reflects weight writes from the edge after the write.

## Test plan
Parameters for all scenarios: N_INPUTS=2, DATA_W=16, FRAC_W=8, LR_SHIFT=3.
- Reset, then in_vec=(0x0100,0x0100), mask=11, learn_en=0, step mode → `out_act`=0x0100 at T+4, one-cycle `out_valid`, `in_ready` high at T+5.
- in_vec=(0x0000,0x0100), mask=01 → sum 0 → `out_act`=0 (strict >0).
- in_vec=(0x0100,0x0000), mask=11, learn_en=1, err_in=0x0100 → back_err=(0x0100,0x0100), w0=0x0120, w1=0x0100, bias=0x0020 via `w_rd_data`; `back_valid` at E+4.
- ReLU mode, in_vec=(0x7FFF,0x7FFF), weights 1.0 → `out_act`=0x7FFF (saturated). Negative sum → 0.
- learn_en=1, hold `err_valid` low for 10 cycles → `out_valid`/`out_act` stable throughout; `err_valid` pulsed during IDLE has no effect.
- Assert `rst` during the 2nd MAC cycle and again during UPDATE → `in_ready`=1 next cycle, `out_valid`/`back_valid` never assert, weights read back 0x0100, bias 0.

Source files
------------

// File: rtl/learning_neuron_fx.sv
// learning_neuron_fx: serial fixed-point neuron with on-chip gradient update and error back-propagation
module learning_neuron_fx #(
    parameter int N_INPUTS  = 32,
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 8,
    parameter int LR_SHIFT  = 3,
    parameter int ACT_MODE  = 0,
    parameter int W_INIT    = 1 << FRAC_W,
    parameter int BIAS_INIT = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_INPUTS*DATA_W-1:0]     in_vec,
    input  logic [N_INPUTS-1:0]            en_mask,
    input  logic                           learn_en,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_act,
    input  logic                           err_valid,
    input  logic [DATA_W-1:0]              err_in,
    output logic                           back_valid,
    output logic [N_INPUTS*DATA_W-1:0]     back_err,
    input  logic [$clog2(N_INPUTS+1)-1:0]  w_rd_idx,
    output logic [DATA_W-1:0]              w_rd_data
);
    localparam int IW    = $clog2(N_INPUTS + 1);
    localparam int ACC_W = 2 * DATA_W + IW;
    localparam int PW    = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        return v > SAT_HI ? SAT_HI[DATA_W-1:0] : v < SAT_LO ? SAT_LO[DATA_W-1:0] : v[DATA_W-1:0];
    endfunction

    typedef enum logic [2:0] {IDLE, MAC, ACT, WAIT_ERR, UPDATE, DONE} state_t;

    state_t                     state;
    logic [IW-1:0]              idx;
    logic signed [ACC_W-1:0]    acc;
    logic [N_INPUTS*DATA_W-1:0] vec_r;
    logic [N_INPUTS-1:0]        mask_r;
    logic                       learn_r;
    logic signed [DATA_W-1:0]   err_r;
    // entries 0..N_INPUTS-1 are the weights, entry N_INPUTS is the bias
    logic signed [DATA_W-1:0]   w [N_INPUTS+1];
    logic signed [DATA_W-1:0]   x_i, w_i, sum_sat;
    logic signed [PW-1:0]       p_xw, p_ex, p_ew;
    logic [DATA_W-1:0]          act;
    logic                       en_i, last;

    assign x_i       = vec_r[DATA_W*idx +: DATA_W];
    assign w_i       = w[idx];
    assign en_i      = |(mask_r & (N_INPUTS'(1) << idx));
    assign last      = idx == IW'(N_INPUTS - 1);
    assign p_xw      = PW'(x_i) * PW'(w_i);
    assign p_ex      = PW'(err_r) * PW'(x_i);
    assign p_ew      = PW'(err_r) * PW'(w_i);
    assign sum_sat   = sat(acc >>> FRAC_W);
    assign in_ready  = state == IDLE && !rst;
    assign w_rd_data = w[w_rd_idx];

    // activation of the saturated sum: strict-positive step or clamped ReLU
    always_comb begin
        act = ACT_MODE == 1 ? (sum_sat < 0 ? '0 : sum_sat) : (sum_sat > 0 ? DATA_W'(1 << FRAC_W) : '0);
    end

    // control FSM with serial MAC, activation register and per-input weight update
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            vec_r      <= '0;
            mask_r     <= '0;
            learn_r    <= 1'b0;
            err_r      <= '0;
            out_valid  <= 1'b0;
            out_act    <= '0;
            back_valid <= 1'b0;
            back_err   <= '0;
            for (int i = 0; i < N_INPUTS; i++) w[i] <= DATA_W'(W_INIT);
            w[N_INPUTS] <= DATA_W'(BIAS_INIT);
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    vec_r   <= in_vec;
                    mask_r  <= en_mask;
                    learn_r <= learn_en;
                    acc     <= ACC_W'(w[N_INPUTS]) <<< FRAC_W;
                    idx     <= '0;
                    state   <= MAC;
                end
                MAC: begin
                    acc <= acc + (en_i ? ACC_W'(p_xw) : '0);
                    idx <= idx + 1'b1;
                    if (last) state <= ACT;
                end
                ACT: begin
                    out_act   <= act;
                    out_valid <= 1'b1;
                    state     <= WAIT_ERR;
                end
                WAIT_ERR: if (!learn_r) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end else if (err_valid) begin
                    err_r     <= err_in;
                    out_valid <= 1'b0;
                    idx       <= '0;
                    state     <= UPDATE;
                end
                UPDATE: begin
                    if (en_i) begin
                        back_err[DATA_W*idx +: DATA_W] <= sat(ACC_W'(p_ew) >>> FRAC_W);
                        w[idx] <= sat(ACC_W'(w_i) + (ACC_W'(p_ex) >>> (FRAC_W + LR_SHIFT)));
                    end else begin
                        back_err[DATA_W*idx +: DATA_W] <= '0;
                    end
                    if (idx == '0) w[N_INPUTS] <= sat(ACC_W'(w[N_INPUTS]) + (ACC_W'(err_r) >>> LR_SHIFT));
                    idx <= idx + 1'b1;
                    if (last) state <= DONE;
                end
                DONE: begin
                    back_valid <= !back_valid;
                    if (back_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
